// File: rtl/ac_motor_phase_scheduler_if.sv
// Command/status bundle between the inverter controller and the phase scheduler.
// The controller side uses the master modport, the scheduler uses slave.
interface ac_motor_phase_scheduler_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic             stop;
    logic             fault_in;
    logic             fault_clr;
    logic [CNT_W-1:0] duty_u;
    logic [CNT_W-1:0] duty_v;
    logic [CNT_W-1:0] duty_w;
    logic [7:0]       delay_req;

    logic             s_in_u;
    logic             s_in_v;
    logic             s_in_w;
    logic             sw_enable;
    logic [7:0]       delay;
    logic [2:0]       state;
    logic             carrier_sync;
    logic             fault_latched;

    modport master (
        output start, stop, fault_in, fault_clr, duty_u, duty_v, duty_w, delay_req,
        input  s_in_u, s_in_v, s_in_w, sw_enable, delay, state, carrier_sync, fault_latched
    );

    modport slave (
        input  start, stop, fault_in, fault_clr, duty_u, duty_v, duty_w, delay_req,
        output s_in_u, s_in_v, s_in_w, sw_enable, delay, state, carrier_sync, fault_latched
    );
endinterface

// File: rtl/ac_motor_phase_scheduler.sv
// Three-phase PWM sequencer: triangle carrier, precharge/run/drain/fault control.
// Define AC_MOTOR_MIN_PULSE_EN to clamp duties so no pulse is shorter than the dead time.
module ac_motor_phase_scheduler #(
    parameter int CNT_W         = 10,
    parameter int PERIOD        = 500,
    parameter int PRECHARGE_CYC = 256,
    parameter int DRAIN_CYC     = 300
) (
    input logic                    clk,
    input logic                    rst_n,
    ac_motor_phase_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        RUN       = 3'd2,
        DRAIN     = 3'd3,
        FAULT     = 3'd4
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int SC_W   = $clog2((PRECHARGE_CYC > DRAIN_CYC ? PRECHARGE_CYC : DRAIN_CYC) + 1);
    localparam int HALF_I = PERIOD / 2;
    localparam int TOP_I  = PERIOD - 1;
    localparam int PRE_I  = PRECHARGE_CYC - 1;
    localparam int DRN_I  = DRAIN_CYC - 1;
    localparam logic [CNT_W:0]   PER  = PERIOD[CNT_W:0];
    localparam logic [CNT_W:0]   HALF = HALF_I[CNT_W:0];
    localparam logic [CNT_W-1:0] TOP  = TOP_I[CNT_W-1:0];
    localparam logic [SC_W-1:0]  PRE_LAST = PRE_I[SC_W-1:0];
    localparam logic [SC_W-1:0]  DRN_LAST = DRN_I[SC_W-1:0];

    state_t           state_q, next_state;
    dir_t             dir_q, dir_nxt;
    logic [SC_W-1:0]  state_cnt_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       delay_q;
    logic [CNT_W-1:0] duty_q   [3];
    logic [CNT_W-1:0] duty_raw [3];
    logic [CNT_W:0]   shaped   [3];
    logic [2:0]       s_in_q;
    logic             sw_en_q, sync_q, fault_q;
    logic             run_hold, load_duty, sync_nxt;

    assign duty_raw[0] = bus.duty_u;
    assign duty_raw[1] = bus.duty_v;
    assign duty_raw[2] = bus.duty_w;

    always_comb begin
        // NOTE: every variable gets its default first so no path infers a latch.
        next_state = state_q;
        if (bus.fault_in) begin
            next_state = FAULT;
        end else begin
            unique case (state_q)
                IDLE:      if (!bus.stop && bus.start) next_state = PRECHARGE;
                PRECHARGE: if (bus.stop) next_state = DRAIN;
                           else if (state_cnt_q == PRE_LAST) next_state = RUN;
                RUN:       if (bus.stop) next_state = DRAIN;
                DRAIN:     if (state_cnt_q == DRN_LAST) next_state = IDLE;
                FAULT:     if (bus.fault_clr) next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    assign run_hold = (state_q == RUN) && (next_state == RUN);

    // Endpoints repeat once as the direction flips, giving a 2*PERIOD cycle.
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = UP;
        if (run_hold) begin
            if (dir_q == UP) begin
                if (cnt_q == TOP) begin
                    cnt_nxt = cnt_q;
                    dir_nxt = DOWN;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end else if (cnt_q != '0) begin
                cnt_nxt = cnt_q - 1'b1;
                dir_nxt = DOWN;
            end
        end
    end

    assign sync_nxt  = run_hold && (cnt_nxt == '0) && (dir_nxt == DOWN);
    assign load_duty = (next_state == RUN) &&
                       ((state_q != RUN) || ((cnt_q == '0) && (dir_q == DOWN)));

`ifdef AC_MOTOR_MIN_PULSE_EN
    logic [CNT_W:0] dly;
    assign dly = {{(CNT_W-7){1'b0}}, delay_q};
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            shaped[i] = ({1'b0, duty_raw[i]} > PER) ? PER : {1'b0, duty_raw[i]};
`ifdef AC_MOTOR_MIN_PULSE_EN
            if (dly >= HALF)
                shaped[i] = (shaped[i] < HALF) ? '0 : PER;
            else if (shaped[i] < dly)
                shaped[i] = '0;
            else if (shaped[i] > PER - dly)
                shaped[i] = PER;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q     <= IDLE;
            state_cnt_q <= '0;
            cnt_q       <= '0;
            dir_q       <= UP;
            delay_q     <= '0;
            s_in_q      <= '0;
            sw_en_q     <= 1'b0;
            sync_q      <= 1'b0;
            fault_q     <= 1'b0;
            for (int i = 0; i < 3; i++) duty_q[i] <= '0;
        end else begin
            state_q     <= next_state;
            state_cnt_q <= ((next_state == state_q) &&
                            ((state_q == PRECHARGE) || (state_q == DRAIN))) ?
                           state_cnt_q + 1'b1 : '0;
            cnt_q       <= cnt_nxt;
            dir_q       <= dir_nxt;
            sw_en_q     <= (next_state == PRECHARGE) || (next_state == RUN) ||
                           (next_state == DRAIN);
            sync_q      <= sync_nxt;
            fault_q     <= (next_state == FAULT);
            // Dead time may only move while the switches are guaranteed off.
            if (state_q == IDLE) delay_q <= bus.delay_req;
            for (int i = 0; i < 3; i++) begin
                if (load_duty) duty_q[i] <= shaped[i][CNT_W-1:0];
                s_in_q[i] <= run_hold && (cnt_q < duty_q[i]);
            end
        end
    end

    assign bus.s_in_u        = s_in_q[0];
    assign bus.s_in_v        = s_in_q[1];
    assign bus.s_in_w        = s_in_q[2];
    assign bus.sw_enable     = sw_en_q;
    assign bus.delay         = delay_q;
    assign bus.state         = state_q;
    assign bus.carrier_sync  = sync_q;
    assign bus.fault_latched = fault_q;

endmodule
